// File: rtl/therm_gen.sv
// Binary-to-thermometer generator for the 15-comparator flash ADC output chain.
// Sources direct 4-bit codes, or an internal up-ramp / triangle sweep with programmable dwell.
module therm_gen #(
   parameter int DWELL_W  = 8,
   parameter int MAX_CODE = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic [3:0]         din,
   input  logic               din_valid,
   output logic               din_ready,
   input  logic [DWELL_W-1:0] dwell,
   output logic [14:0]        therm_out,
   output logic [3:0]         code_out,
   output logic               therm_valid,
   input  logic               therm_ready,
   output logic               wrap
);

   typedef enum logic [1:0] {
      M_DIRECT = 2'b00,
      M_RAMP   = 2'b01,
      M_TRI    = 2'b10,
      M_HOLD   = 2'b11
   } mode_t;

   localparam logic [3:0] TOP = 4'(MAX_CODE);

   mode_t              mode_q;
   logic [DWELL_W-1:0] cnt;
   logic               dir_down;
   logic               adv;
   logic [3:0]         step_code;
   logic               step_dir_down;
   logic               step_wrap;

   function automatic logic [3:0] clamp(input logic [3:0] c);
      return (c > TOP) ? TOP : c;
   endfunction

   function automatic logic [14:0] to_therm(input logic [3:0] c);
      return (15'd1 << c) - 15'd1;
   endfunction

   assign adv       = !therm_valid || therm_ready;
   assign din_ready = (mode_q == M_DIRECT) && (mode == mode_q) && adv;

   // Next sweep code, taken from the code currently on the output.
   always_comb begin
      step_code     = code_out;
      step_dir_down = dir_down;
      step_wrap     = 1'b0;
      if (mode_q == M_RAMP) begin
         if (code_out >= TOP) begin
            step_code = 4'd0;
            step_wrap = 1'b1;
         end else begin
            step_code = code_out + 4'd1;
         end
      end else if (!dir_down) begin
         step_code = code_out + 4'd1;
         if (code_out == TOP - 4'd1) step_dir_down = 1'b1;
      end else begin
         step_code = code_out - 4'd1;
         if (code_out == 4'd1) begin
            step_dir_down = 1'b0;
            step_wrap     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q      <= M_DIRECT;
         cnt         <= '0;
         dir_down    <= 1'b0;
         therm_out   <= '0;
         code_out    <= '0;
         therm_valid <= 1'b0;
         wrap        <= 1'b0;
      end else if (mode != mode_q) begin
         mode_q      <= mode_t'(mode);
         cnt         <= '0;
         dir_down    <= 1'b0;
         therm_valid <= 1'b0;
         wrap        <= 1'b0;
      end else if (adv) begin
         case (mode_q)
            M_DIRECT: begin
               wrap <= 1'b0;
               if (din_valid && din_ready) begin
                  therm_out   <= to_therm(clamp(din));
                  code_out    <= clamp(din);
                  therm_valid <= 1'b1;
               end else begin
                  therm_valid <= 1'b0;
               end
            end
            M_RAMP, M_TRI: begin
               // First accepted cycle after entry presents code 0; the dwell count starts there.
               if (!therm_valid) begin
                  therm_out   <= '0;
                  code_out    <= '0;
                  therm_valid <= 1'b1;
                  cnt         <= '0;
                  wrap        <= 1'b0;
               end else if (cnt == dwell) begin
                  cnt       <= '0;
                  code_out  <= step_code;
                  therm_out <= to_therm(step_code);
                  dir_down  <= step_dir_down;
                  wrap      <= step_wrap;
               end else begin
                  cnt  <= cnt + DWELL_W'(1);
                  wrap <= 1'b0;
               end
            end
            default: wrap <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_therm_gen.sv
// Bench for therm_gen: direct-mode vector table, randomized direct and sweep traffic
// against a sequence-level reference model, plus hold and asynchronous-reset sequences.
module tb_therm_gen;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic [3:0]  din;
   logic        din_valid;
   logic        din_ready;
   logic [7:0]  dwell;
   logic [14:0] therm_out;
   logic [3:0]  code_out;
   logic        therm_valid;
   logic        therm_ready;
   logic        wrap;

   int checks   = 0;
   int failures = 0;

   therm_gen #(.DWELL_W(8), .MAX_CODE(14)) dut (
      .clk(clk), .rst(rst), .mode(mode), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .dwell(dwell), .therm_out(therm_out), .code_out(code_out),
      .therm_valid(therm_valid), .therm_ready(therm_ready), .wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] din;
      logic       dv;
      logic       rdy;
      int         exp_ready;
      int         exp_code;
      int         exp_therm;
      int         exp_valid;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference thermometer word: bit k set for every level below code.
   function automatic int thermo(input int c);
      int t = 0;
      for (int k = 0; k < 15; k++) if (k < c) t |= (1 << k);
      return t;
   endfunction

   // Comparator-side encoder: length of the run of ones from bit 0; 15 flags a bubble.
   function automatic int comp15(input logic [14:0] t);
      int n = 0;
      while (n < 15 && t[n]) n++;
      for (int k = n; k < 15; k++) if (t[k]) return 15;
      return n;
   endfunction

   function automatic int sweep_code(input int m, input int i);
      int j;
      if (m == 1) return i % 15;
      j = i % 28;
      return (j <= 14) ? j : 28 - j;
   endfunction

   task automatic sweep(input logic [1:0] m, input int dw, input int n, input bit bp,
                        output int nwrap);
      int k, i, exp_code, period;
      bit exp_wrap, rdy, adv;
      period      = (m == 2'b01) ? 15 : 28;
      mode        = m;
      dwell       = 8'(dw);
      din_valid   = 1'b0;
      therm_ready = 1'b1;
      tick();
      chk("entry_valid", int'(therm_valid), 0);
      chk("entry_wrap", int'(wrap), 0);
      k = 0; exp_wrap = 0; nwrap = 0; exp_code = 0;
      for (int e = 0; e < n; e++) begin
         rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         therm_ready = rdy;
         adv = (k == 0) || rdy;
         tick();
         if (adv) begin
            k++;
            i = (k - 1) / (dw + 1);
            exp_code = sweep_code(int'(m), i);
            exp_wrap = ((k - 1) % (dw + 1) == 0) && (i > 0) && (i % period == 0);
         end
         chk("sweep_code", int'(code_out), exp_code);
         chk("sweep_therm", int'(therm_out), thermo(exp_code));
         chk("sweep_valid", int'(therm_valid), 1);
         chk("sweep_wrap", int'(wrap), int'(exp_wrap));
         if (wrap) nwrap++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int m_code, transfers, cyc, nw, dw;
      bit m_valid, dv, rdy, exp_ready;
      logic [3:0] d;

      tbl[0] = '{4'd5,  1'b1, 1'b1, 1, 5,  'h001F, 1};
      tbl[1] = '{4'd15, 1'b1, 1'b1, 1, 14, 'h3FFF, 1};
      tbl[2] = '{4'd0,  1'b1, 1'b1, 1, 0,  'h0000, 1};
      tbl[3] = '{4'd3,  1'b0, 1'b1, 1, 0,  'h0000, 0};
      tbl[4] = '{4'd9,  1'b1, 1'b0, 1, 9,  'h01FF, 1};
      tbl[5] = '{4'd2,  1'b1, 1'b0, 0, 9,  'h01FF, 1};
      tbl[6] = '{4'd2,  1'b1, 1'b1, 1, 2,  'h0003, 1};
      tbl[7] = '{4'd14, 1'b1, 1'b1, 1, 14, 'h3FFF, 1};
      tbl[8] = '{4'd7,  1'b1, 1'b1, 1, 7,  'h007F, 1};

      rst = 1'b1; mode = 2'b00; din = 4'd0; din_valid = 1'b0; dwell = 8'd0; therm_ready = 1'b1;
      #3;
      chk("rst_therm", int'(therm_out), 0);
      chk("rst_code", int'(code_out), 0);
      chk("rst_valid", int'(therm_valid), 0);
      chk("rst_wrap", int'(wrap), 0);
      tick();
      rst = 1'b0;

      foreach (tbl[r]) begin
         din = tbl[r].din; din_valid = tbl[r].dv; therm_ready = tbl[r].rdy;
         #1;
         chk("tbl_din_ready", int'(din_ready), tbl[r].exp_ready);
         tick();
         chk("tbl_code", int'(code_out), tbl[r].exp_code);
         chk("tbl_therm", int'(therm_out), tbl[r].exp_therm);
         chk("tbl_valid", int'(therm_valid), tbl[r].exp_valid);
      end

      // Random direct traffic with backpressure; model carries its own valid/code.
      m_valid = 1'b1; m_code = 7; transfers = 0; cyc = 0;
      while (transfers < 100 && cyc < 2000) begin
         d = 4'($urandom_range(0, 15));
         dv = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         din = d; din_valid = dv; therm_ready = rdy;
         #1;
         exp_ready = !m_valid || rdy;
         chk("rnd_din_ready", int'(din_ready), int'(exp_ready));
         tick();
         if (exp_ready) begin
            if (dv) begin
               m_code = (int'(d) > 14) ? 14 : int'(d);
               m_valid = 1'b1;
               transfers++;
            end else begin
               m_valid = 1'b0;
            end
         end
         chk("rnd_valid", int'(therm_valid), int'(m_valid));
         chk("rnd_code", int'(code_out), m_code);
         chk("rnd_comp15", comp15(therm_out), m_code);
         cyc++;
      end
      chk("rnd_transfers", transfers, 100);

      sweep(2'b01, 2, 91, 1'b0, nw);
      chk("ramp_wrap_count", nw, 2);
      sweep(2'b10, 0, 57, 1'b0, nw);
      chk("tri_wrap_count", nw, 2);
      dw = $urandom_range(0, 3);
      sweep(2'b01, dw, 150, 1'b1, nw);
      dw = $urandom_range(0, 3);
      sweep(2'b10, dw, 200, 1'b1, nw);

      // Hold freezes the word reached by the ramp.
      sweep(2'b01, 0, 8, 1'b0, nw);
      mode = 2'b11; therm_ready = 1'b0;
      tick();
      chk("hold_entry_valid", int'(therm_valid), 0);
      for (int h = 0; h < 10; h++) begin
         therm_ready = ($urandom_range(0, 1) != 0);
         tick();
         chk("hold_therm", int'(therm_out), 'h007F);
         chk("hold_code", int'(code_out), 7);
         chk("hold_valid", int'(therm_valid), 0);
         chk("hold_wrap", int'(wrap), 0);
      end
      sweep(2'b01, 0, 20, 1'b1, nw);

      // Asynchronous reset on the descending leg at code 9.
      sweep(2'b10, 0, 20, 1'b0, nw);
      chk("pre_rst_code", int'(code_out), 9);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_therm", int'(therm_out), 0);
      chk("async_rst_code", int'(code_out), 0);
      chk("async_rst_valid", int'(therm_valid), 0);
      chk("async_rst_wrap", int'(wrap), 0);
      rst = 1'b0;
      sweep(2'b10, 0, 30, 1'b1, nw);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/therm_gen.md
Name: therm_gen

Overview:
- Binary-to-thermometer generator for the 15-comparator flash ADC path; the inverse of the comparator thermometer encoder.
- Drives 15-bit thermometer words (bit k set for every level k < code) into the digital-output chain, so the encoder and downstream logic can be exercised without the analog front end.
- Sources: externally supplied 4-bit codes (direct mode), or an internal up-ramp or triangle sweep with programmable dwell.

Parameters:
- DWELL_W, 8, width of the dwell register and dwell counter.
- MAX_CODE, 14, highest code emitted; fixed to 14 for the 15-bit word and exposed for checking only.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  2  00 direct, 01 ramp up, 10 triangle, 11 hold
- din  in  4  binary code input (direct mode)
- din_valid  in  1  din qualifier
- din_ready  out  1  generator accepts din this cycle
- dwell  in  DWELL_W  extra accepted cycles each ramp code is held
- therm_out  out  15  thermometer word, registered
- code_out  out  4  binary shadow of therm_out, registered
- therm_valid  out  1  therm_out/code_out valid
- therm_ready  in  1  consumer accepts therm_out
- wrap  out  1  one-cycle pulse at sweep completion

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: therm_out=0, code_out=0, therm_valid=0, wrap=0, dwell counter=0, ramp code=0, direction=up, mode_q=00.
- Accept condition: adv = !therm_valid || therm_ready. Output registers change only when adv is true; otherwise all outputs and the dwell counter hold.
- Encoding: therm_out = (1<<code)-1 for code 0..14. code_out = code. Any input code 15 clamps to 14, giving therm_out=15'h3FFF; all-ones is never emitted.
- Mode change: mode is registered into mode_q. When mode != mode_q:
  - dwell counter clears, ramp code resets to 0, direction resets to up.
  - In that cycle therm_valid goes to 0 and wrap is 0.
  - The new mode's behaviour starts on the next cycle.
- Direct mode (00):
  - din_ready = (mode_q==00) && (mode==mode_q) && adv, combinational.
  - On din_valid && din_ready: therm_out/code_out load the clamped din next edge, therm_valid=1 (1-cycle latency).
  - If adv is true with no transfer, therm_valid drops to 0.
  - Full throughput: one word per cycle while therm_ready=1.
- Ramp up (01):
  - din_ready=0; therm_valid=1 from the first cycle after entry, starting at code 0.
  - Dwell counter increments on each adv cycle. When it equals dwell: counter clears and code steps 0,1,...,14,0,...
  - Each code is presented for dwell+1 accepted cycles; dwell=0 steps every accepted cycle.
  - wrap pulses 1 for the single cycle in which code 14 -> 0 is registered.
- Triangle (10):
  - Same dwell rule; sequence 0,1,...,14,13,...,1,0,1,...
  - Direction flips up->down on registering 14 and down->up on registering 0.
  - wrap pulses when 0 is registered on the descending leg.
  - Period = 28*(dwell+1) accepted cycles.
- Hold (11): din_ready=0. therm_out, code_out and therm_valid freeze at their current values; dwell counter, code and direction freeze; wrap=0.
- dwell changing mid-sweep: takes effect at the next compare. If dwell drops below the current counter value, the counter continues to wrap at 2^DWELL_W before matching; no special handling.
- Backpressure in ramp modes: the counter pauses while therm_valid && !therm_ready; no codes are skipped.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
- rst=1 then release, mode=00, din=5, din_valid=1, therm_ready=1 -> din_ready=1; next cycle therm_out=15'h001F, code_out=5, therm_valid=1. din=15 -> therm_out=15'h3FFF, code_out=14.
- Direct, therm_ready=0 after one transfer -> din_ready=0, output held. Release therm_ready -> next din accepted; no word lost or duplicated over 100 random codes (checked through the comp15 encoder round-trip).
- mode=01, dwell=2, therm_ready=1 -> each code held 3 cycles, 0..14. wrap=1 exactly once per 45 cycles, coincident with code_out 14->0.
- mode=10, dwell=0 -> codes 0..14..0 over a 28-cycle period. wrap once per period at 0 on the descending leg; no repeated code at 14.
- Ramp at code 7, switch to mode=11 for 10 cycles -> outputs frozen at 0x007F. Switch to 01 -> one cycle therm_valid=0, then the sweep restarts at 0.
- Assert rst asynchronously mid-triangle at code 9, descending -> outputs 0 and therm_valid=0 without a clk edge. After release, the sweep restarts from 0 upward.
